lsu_byte_seq: RTL and testbench

Load/store sequencer between the core's memory stage and a byte-wide data memory port. It accepts one load or store request with the func3-coded access length that the control unit emits (`l_length`/`s_length`). It performs the access as 1, 2 or 4 serial byte transactions, little-endian, over a req/ack memory handshake, then returns load data sign- or zero-extended to 32 bits. It is the consumer end of the control unit's memory-control outputs and is intended for the multicycle core.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_ext.sv | 21 ++
 rtl/lsu_byte_seq.sv | 138 +++++++++++++
 tb/tb_lsu_byte_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: func3 access
// lengths, sequencer states and the length-to-byte-count mapping.
package lsu_pkg;

  localparam logic [2:0] LEN_B  = 3'b000;
  localparam logic [2:0] LEN_H  = 3'b001;
  localparam logic [2:0] LEN_W  = 3'b010;
  localparam logic [2:0] LEN_BU = 3'b100;
  localparam logic [2:0] LEN_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  // Only bits [1:0] carry the size; bit 2 selects zero-extension for loads.
  function automatic logic [2:0] byte_count(input logic [2:0] len);
    case (len[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load-data extender: turns an assembled little-endian 32-bit buffer into the
// architectural load result for the given func3 length.
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [31:0] i_buf,
  input  logic [2:0]  i_len,
  output logic [31:0] o_data
);

  always_comb begin
    case (i_len)
      LEN_B:   o_data = {{24{i_buf[7]}}, i_buf[7:0]};
      LEN_H:   o_data = {{16{i_buf[15]}}, i_buf[15:0]};
      LEN_BU:  o_data = {24'd0, i_buf[7:0]};
      LEN_HU:  o_data = {16'd0, i_buf[15:0]};
      default: o_data = i_buf;
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: performs one request as 1, 2 or 4 little-endian byte
// transactions over a req/ack port and returns extended load data.
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_length,
  output logic              rsp_vld,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_wren;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [2:0]        r_len;
  logic [1:0]        r_idx;
  logic              w_accept;
  logic              w_len_ok;
  logic              w_misal;
  logic              w_legal;
  logic              w_last;
  logic              w_ack;
  logic [31:0]       w_ext;

  assign w_accept = (r_state == IDLE) && req_vld;
  assign w_ack    = (r_state == ACCESS) && mem_ack;
  assign w_last   = ({1'b0, r_idx} == (byte_count(r_len) - 3'd1));

  // Request legality: length code by direction, then natural alignment.
  always_comb begin
    w_len_ok = 1'b1;
    if (req_wren) begin
      w_len_ok = (req_length[1:0] != 2'b11);
    end else begin
      w_len_ok = (req_length == LEN_B)  || (req_length == LEN_H) ||
                 (req_length == LEN_W)  || (req_length == LEN_BU) ||
                 (req_length == LEN_HU);
    end
    w_misal = 1'b0;
    case (req_length[1:0])
      2'b01:   w_misal = req_addr[0];
      2'b10:   w_misal = |req_addr[1:0];
      default: w_misal = 1'b0;
    endcase
    w_legal = w_len_ok && !w_misal;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_legal ? ACCESS : RESP;
      ACCESS:  if (mem_ack && w_last) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wren  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_buf   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_wren  <= req_wren;
      r_err   <= !w_legal;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_buf   <= '0;
      r_len   <= req_length;
      r_idx   <= '0;
    end else if (w_ack) begin
      if (!r_wren) r_buf[{r_idx, 3'b000} +: 8] <= mem_rdata;
      if (!w_last) r_idx <= r_idx + 2'd1;
    end
  end

  lsu_ext u_ext (
    .i_buf  (r_buf),
    .i_len  (r_len),
    .o_data (w_ext)
  );

  // Outputs decode registered state only, so mem_ack never reaches mem_req.
  always_comb begin
    req_rdy   = 1'b0;
    rsp_vld   = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: req_rdy = 1'b1;
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = r_wren;
        mem_addr  = r_addr + ADDR_W'(r_idx);
        mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
      end
      RESP: begin
        rsp_vld   = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_err || r_wren) ? 32'd0 : w_ext;
      end
      default: req_rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Scoreboard bench for lsu_byte_seq: directed requests push expected byte
// transactions and responses; a memory responder and a response monitor check them.
module tb_lsu_byte_seq;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } mem_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_wren = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_length = '0;
  logic        rsp_vld;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   g_wait = 0;
  logic stray_ack = 1'b0;
  mem_t mq[$];
  rsp_t rq[$];

  lsu_byte_seq #(.ADDR_W(32)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_wren   (req_wren),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_length (req_length),
    .rsp_vld    (rsp_vld),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata;
    mq.push_back(m);
  endtask

  task automatic issue(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] len, input logic exp_rsp, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, output int t_acc);
    logic acc;
    rsp_t r;
    acc = 1'b0;
    t_acc = -1;
    @(negedge i_clk);
    req_vld = 1'b1; req_wren = wren; req_addr = addr; req_wdata = wdata; req_length = len;
    for (int k = 0; k < 200 && !acc; k++) begin
      #1;
      if (req_rdy) begin
        acc = 1'b1;
        t_acc = cyc;
        if (exp_rsp) begin
          r.rdata = exp_rdata; r.err = exp_err; r.cyc = cyc + lat;
          rq.push_back(r);
        end
      end
      @(negedge i_clk);
    end
    req_vld = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_wait(input int n);
    for (int k = 0; k < 200; k++) begin
      if (k >= n && rq.size() == 0 && !mem_req) break;
      @(negedge i_clk);
    end
  endtask

  // Memory responder: checks each byte transaction and acks after g_wait cycles.
  mem_t cur;
  logic busy = 1'b0;
  int   wcnt = 0;
  always @(negedge i_clk) begin
    if (i_reset) begin
      mem_ack = 1'b0;
      busy = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        if (mq.size() == 0) begin
          chk("mem_unexpected_req", mem_addr, 32'hFFFF_FFFF);
          cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.rdata = 8'h00;
        end else begin
          cur = mq.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, cur.wdata});
        end
        busy = 1'b1;
        wcnt = 0;
      end else begin
        chk("mem_hold", {mem_we, mem_wdata, mem_addr[22:0]},
            {cur.we, cur.wdata, cur.addr[22:0]});
      end
      if (wcnt >= g_wait) begin
        mem_ack = 1'b1;
        mem_rdata = cur.rdata;
        busy = 1'b0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 8'h5A;
        wcnt++;
      end
    end else begin
      mem_ack = stray_ack;
      mem_rdata = 8'hA5;
      busy = 1'b0;
    end
  end

  // Response monitor.
  always @(negedge i_clk) begin
    rsp_t e;
    if (!i_reset && rsp_vld) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", rsp_rdata, 32'hDEAD_0000);
      end else begin
        e = rq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2;
    #3;
    chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
    chk("rst_outs", {rsp_vld, rsp_err, mem_req, mem_we, mem_wdata}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge i_clk); @(negedge i_clk);
    #2 i_reset = 1'b0;

    // LB sign-extended, zero-wait.
    exp_mem(1'b0, 32'h103, 8'h00, 8'h80);
    issue(1'b0, 32'h103, 32'h0, 3'b000, 1'b1, 32'hFFFF_FF80, 1'b0, 2, t1);
    idle_wait(2);
    // LHU and LH.
    exp_mem(1'b0, 32'h200, 8'h00, 8'h34);
    exp_mem(1'b0, 32'h201, 8'h00, 8'h85);
    issue(1'b0, 32'h200, 32'h0, 3'b101, 1'b1, 32'h0000_8534, 1'b0, 3, t1);
    idle_wait(2);
    exp_mem(1'b0, 32'h202, 8'h00, 8'h34);
    exp_mem(1'b0, 32'h203, 8'h00, 8'h85);
    issue(1'b0, 32'h202, 32'h0, 3'b001, 1'b1, 32'hFFFF_8534, 1'b0, 3, t1);
    idle_wait(2);
    // LW and LBU.
    exp_mem(1'b0, 32'h20, 8'h00, 8'h11);
    exp_mem(1'b0, 32'h21, 8'h00, 8'h22);
    exp_mem(1'b0, 32'h22, 8'h00, 8'h33);
    exp_mem(1'b0, 32'h23, 8'h00, 8'h84);
    issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b1, 32'h8433_2211, 1'b0, 5, t1);
    idle_wait(2);
    exp_mem(1'b0, 32'h5, 8'h00, 8'h80);
    issue(1'b0, 32'h5, 32'h0, 3'b100, 1'b1, 32'h0000_0080, 1'b0, 2, t1);
    idle_wait(2);
    // Stores: SB, SB via length 100, SH.
    exp_mem(1'b1, 32'h7, 8'h78, 8'h00);
    issue(1'b1, 32'h7, 32'h1234_5678, 3'b000, 1'b1, 32'h0, 1'b0, 2, t1);
    idle_wait(2);
    exp_mem(1'b1, 32'h9, 8'hAB, 8'h00);
    issue(1'b1, 32'h9, 32'h0000_00AB, 3'b100, 1'b1, 32'h0, 1'b0, 2, t1);
    idle_wait(2);
    exp_mem(1'b1, 32'hA, 8'h0D, 8'h00);
    exp_mem(1'b1, 32'hB, 8'hF0, 8'h00);
    issue(1'b1, 32'hA, 32'hCAFE_F00D, 3'b001, 1'b1, 32'h0, 1'b0, 3, t1);
    idle_wait(2);
    // SW with one wait cycle per byte.
    g_wait = 1;
    exp_mem(1'b1, 32'h10, 8'hEF, 8'h00);
    exp_mem(1'b1, 32'h11, 8'hBE, 8'h00);
    exp_mem(1'b1, 32'h12, 8'hAD, 8'h00);
    exp_mem(1'b1, 32'h13, 8'hDE, 8'h00);
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b1, 32'h0, 1'b0, 9, t1);
    idle_wait(2);
    g_wait = 0;
    // Error cases: misaligned and illegal lengths, none touch memory.
    issue(1'b0, 32'h102, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, 1, t1);
    idle_wait(1);
    issue(1'b1, 32'h1, 32'hFFFF_FFFF, 3'b001, 1'b1, 32'h0, 1'b1, 1, t1);
    idle_wait(1);
    issue(1'b0, 32'h3, 32'h0, 3'b101, 1'b1, 32'h0, 1'b1, 1, t1);
    idle_wait(1);
    issue(1'b0, 32'h0, 32'h0, 3'b011, 1'b1, 32'h0, 1'b1, 1, t1);
    idle_wait(1);
    issue(1'b0, 32'h0, 32'h0, 3'b110, 1'b1, 32'h0, 1'b1, 1, t1);
    idle_wait(1);
    issue(1'b1, 32'h0, 32'h0, 3'b011, 1'b1, 32'h0, 1'b1, 1, t1);
    idle_wait(1);

    // Reset during the second byte of an LW: no response expected.
    g_wait = 3;
    exp_mem(1'b0, 32'h300, 8'h00, 8'h11);
    exp_mem(1'b0, 32'h301, 8'h00, 8'h22);
    issue(1'b0, 32'h300, 32'h0, 3'b010, 1'b0, 32'h0, 1'b0, 0, t1);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge i_clk);
        if (mem_req && mem_addr == 32'h301) seen = 1'b1;
      end
      chk("reset_reached_byte1", {31'd0, seen}, 32'd1);
    end
    #2 i_reset = 1'b1;
    #1;
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("reset_req_rdy", {31'd0, req_rdy}, 32'd1);
    chk("reset_mem_addr", mem_addr, 32'd0);
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    g_wait = 0;
    chk("reset_mq_empty", mq.size(), 32'd0);
    exp_mem(1'b0, 32'h104, 8'h00, 8'h7F);
    issue(1'b0, 32'h104, 32'h0, 3'b000, 1'b1, 32'h0000_007F, 1'b0, 2, t1);
    idle_wait(2);

    // Stray ack in IDLE has no effect.
    stray_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      #1;
      chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
      chk("stray_req_rdy", {31'd0, req_rdy}, 32'd1);
    end
    @(negedge i_clk);
    stray_ack = 1'b0;

    // req_vld held through ACCESS: second request taken the cycle after RESP.
    g_wait = 2;
    exp_mem(1'b0, 32'h40, 8'h00, 8'h7F);
    issue(1'b0, 32'h40, 32'h0, 3'b000, 1'b1, 32'h0000_007F, 1'b0, 4, t1);
    exp_mem(1'b0, 32'h41, 8'h00, 8'hF0);
    issue(1'b0, 32'h41, 32'h0, 3'b100, 1'b1, 32'h0000_00F0, 1'b0, 4, t2);
    chk("b2b_accept_cycle", t2, t1 + 5);
    idle_wait(3);
    g_wait = 0;

    for (int k = 0; k < 4; k++) @(negedge i_clk);
    chk("end_rsp_queue", rq.size(), 32'd0);
    chk("end_mem_queue", mq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
